// File: rtl/formula_mac.sv
// Sequential multiply-accumulate engine: sum = SUM v[i]*(n+i), one term per clock,
// with a host-writable coefficient RAM, sticky overflow and optional saturation.
module formula_mac #(
  parameter int N     = 8,
  parameter int W     = 16,
  parameter int ACC_W = 32,
  parameter int SAT   = 0
) (
  input  logic                 Clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [W-1:0]         n,
  input  logic                 v_we,
  input  logic [$clog2(N)-1:0] v_addr,
  input  logic [W-1:0]         v_wdata,
  output logic                 busy,
  output logic                 ack,
  output logic [ACC_W-1:0]     sum,
  output logic                 ovf
);

  localparam int AW = $clog2(N);
  localparam int IW = W + AW;
  localparam int PW = W + IW;
  // Temp is wide enough for a full product even when it exceeds ACC_W.
  localparam int SW = ((PW > ACC_W) ? PW : ACC_W) + 1;
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [W-1:0]     v_r [N];
  logic [W-1:0]     n_q_r;
  logic [AW-1:0]    i_r;
  logic [ACC_W-1:0] acc_r;
  logic             acc_ovf_r;

  logic             load_s;
  logic             step_s;
  logic             last_s;
  logic             wr_ok_s;
  logic             addr_ok_s;
  logic             busy_s;
  logic             ack_s;
  logic [W-1:0]     coef_s;
  logic [IW-1:0]    opnd_s;
  logic [PW-1:0]    prod_s;
  logic [SW-1:0]    tmp_s;
  logic             ovf_any_s;
  logic [ACC_W-1:0] acc_nxt_s;

  // FSM state register
  always_ff @(posedge Clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (i_r == LAST) state_s = DONE;
        else             state_s = RUN;
      end
      DONE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM output decode: load/step/complete strobes and coefficient write gate
  always_comb begin
    load_s    = 1'b0;
    step_s    = 1'b0;
    last_s    = 1'b0;
    wr_ok_s   = 1'b0;
    addr_ok_s = ({1'b0, v_addr} < (AW + 1)'(N));
    case (state_r)
      IDLE: begin
        load_s  = start;
        wr_ok_s = v_we & addr_ok_s;
      end
      RUN: begin
        step_s = 1'b1;
        last_s = (i_r == LAST);
      end
      DONE: begin
        load_s  = start;
        wr_ok_s = v_we & addr_ok_s;
      end
      default: begin
        load_s  = 1'b0;
        wr_ok_s = 1'b0;
      end
    endcase
    ack_s  = last_s;
    busy_s = (state_s == RUN);
  end

  // One accumulation step: unsigned full-width product, overflow from any bit above ACC_W-1
  always_comb begin
    coef_s    = v_r[i_r];
    opnd_s    = {{AW{1'b0}}, n_q_r} + {{W{1'b0}}, i_r};
    prod_s    = {{IW{1'b0}}, coef_s} * {{W{1'b0}}, opnd_s};
    tmp_s     = {{(SW - ACC_W){1'b0}}, acc_r} + {{(SW - PW){1'b0}}, prod_s};
    ovf_any_s = acc_ovf_r | (|tmp_s[SW-1:ACC_W]);
    if ((SAT != 0) && ovf_any_s) begin
      acc_nxt_s = {ACC_W{1'b1}};
    end else begin
      acc_nxt_s = tmp_s[ACC_W-1:0];
    end
  end

  // Datapath, coefficient RAM and registered outputs
  always_ff @(posedge Clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        v_r[k] <= W'(1'b1);
      end
      n_q_r     <= {W{1'b0}};
      i_r       <= {AW{1'b0}};
      acc_r     <= {ACC_W{1'b0}};
      acc_ovf_r <= 1'b0;
      busy      <= 1'b0;
      ack       <= 1'b0;
      sum       <= {ACC_W{1'b0}};
      ovf       <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        v_r[v_addr] <= v_wdata;
      end
      if (load_s) begin
        n_q_r     <= n;
        i_r       <= {AW{1'b0}};
        acc_r     <= {ACC_W{1'b0}};
        acc_ovf_r <= 1'b0;
      end else if (step_s) begin
        acc_r     <= acc_nxt_s;
        acc_ovf_r <= ovf_any_s;
        i_r       <= i_r + AW'(1'b1);
      end
      if (last_s) begin
        sum <= acc_nxt_s;
        ovf <= ovf_any_s;
      end
      busy <= busy_s;
      ack  <= ack_s;
    end
  end

endmodule

// File: tb/tb_formula_mac.sv
// Directed bench for formula_mac: wrapping and saturating instances share stimulus;
// expected results are queued at start and compared when ack appears.
module tb_formula_mac;

  localparam int N = 8;
  localparam int W = 16;
  localparam int ACC_W = 32;

  logic              Clk = 1'b0;
  logic              rst;
  logic              start;
  logic [W-1:0]      n;
  logic              v_we;
  logic [2:0]        v_addr;
  logic [W-1:0]      v_wdata;
  logic              busy, ack, ovf;
  logic [ACC_W-1:0]  sum;
  logic              sat_busy, sat_ack, sat_ovf;
  logic [ACC_W-1:0]  sat_sum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_cyc = 0;
  int prev_ack = 0;
  int acks = 0;

  logic [W-1:0]     mv [N];
  logic [ACC_W-1:0] q_sum[$];
  logic             q_ovf[$];
  logic [ACC_W-1:0] q_ssum[$];
  logic             q_sovf[$];

  formula_mac #(.N(N), .W(W), .ACC_W(ACC_W), .SAT(0)) dut (
    .Clk(Clk), .rst(rst), .start(start), .n(n), .v_we(v_we), .v_addr(v_addr),
    .v_wdata(v_wdata), .busy(busy), .ack(ack), .sum(sum), .ovf(ovf)
  );

  formula_mac #(.N(N), .W(W), .ACC_W(ACC_W), .SAT(1)) dut_sat (
    .Clk(Clk), .rst(rst), .start(start), .n(n), .v_we(v_we), .v_addr(v_addr),
    .v_wdata(v_wdata), .busy(sat_busy), .ack(sat_ack), .sum(sat_sum), .ovf(sat_ovf)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Exact 64-bit sum of the model coefficients; returns {ovf, sum}
  function automatic logic [32:0] model(input logic [15:0] nv, input bit sat);
    logic [63:0] t;
    logic        o;
    t = 64'd0;
    for (int i = 0; i < N; i++) begin
      t = t + 64'(mv[i]) * (64'(nv) + 64'(i));
    end
    o = (t > 64'hFFFF_FFFF);
    if (sat && o) return {1'b1, 32'hFFFF_FFFF};
    return {o, t[31:0]};
  endfunction

  task automatic push_exp(input logic [15:0] nv);
    logic [32:0] r0, r1;
    r0 = model(nv, 1'b0);
    r1 = model(nv, 1'b1);
    q_sum.push_back(r0[31:0]);
    q_ovf.push_back(r0[32]);
    q_ssum.push_back(r1[31:0]);
    q_sovf.push_back(r1[32]);
  endtask

  task automatic wr(input int addr, input logic [15:0] data);
    v_we = 1'b1;
    v_addr = 3'(addr);
    v_wdata = data;
    mv[addr] = data;
    tick();
    v_we = 1'b0;
  endtask

  task automatic start_run(input logic [15:0] nv);
    n = nv;
    start = 1'b1;
    push_exp(nv);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_result(input int lat0);
    int lat;
    int bc;
    lat = lat0;
    bc = lat0;
    while (lat < 40) begin
      if (busy === 1'b1) bc++;
      tick();
      lat++;
      if (ack === 1'b1) break;
    end
    ack_cyc = cyc;
    chk("latency", 64'(lat), 64'(N));
    chk("busy_cycles", 64'(bc), 64'(N));
    chk("busy_in_ack", 64'(busy), 64'd0);
    chk("sat_ack", 64'(sat_ack), 64'd1);
    if (q_sum.size() > 0) begin
      chk("sum", 64'(sum), 64'(q_sum.pop_front()));
      chk("ovf", 64'(ovf), 64'(q_ovf.pop_front()));
      chk("sat_sum", 64'(sat_sum), 64'(q_ssum.pop_front()));
      chk("sat_ovf", 64'(sat_ovf), 64'(q_sovf.pop_front()));
    end else begin
      errors++;
      $error("FAIL scoreboard: observed empty queue expected pending entry");
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; n = 16'd0; v_we = 1'b0; v_addr = 3'd0; v_wdata = 16'd0;
    for (int i = 0; i < N; i++) mv[i] = 16'd1;
    tick(); tick();
    rst = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ack", 64'(ack), 64'd0);
    chk("reset_sum", 64'(sum), 64'd0);
    chk("reset_ovf", 64'(ovf), 64'd0);
    tick();

    // 1: default coefficients, n=1
    start_run(16'd1);
    wait_result(0);
    chk("t1_sum36", 64'(sum), 64'd36);
    tick();
    chk("t1_ack_pulse", 64'(ack), 64'd0);
    chk("t1_sum_held", 64'(sum), 64'd36);

    // 2: v[i]=i
    for (int i = 0; i < N; i++) wr(i, 16'(i));
    start_run(16'd0);
    wait_result(0);
    chk("t2_sum140", 64'(sum), 64'd140);
    tick();
    start_run(16'd10);
    wait_result(0);
    chk("t2_sum420", 64'(sum), 64'd420);
    tick();

    // 3: overflow, wrap vs saturate, then defaults again
    for (int i = 0; i < N; i++) wr(i, 16'hFFFF);
    start_run(16'hFFFF);
    wait_result(0);
    chk("t3_ovf", 64'(ovf), 64'd1);
    chk("t3_sat_sum", 64'(sat_sum), 64'hFFFF_FFFF);
    tick();
    for (int i = 0; i < N; i++) wr(i, 16'd1);
    start_run(16'd1);
    wait_result(0);
    chk("t3_clear_ovf", 64'(ovf), 64'd0);
    chk("t3_clear_sat_ovf", 64'(sat_ovf), 64'd0);
    chk("t3_sat_sum36", 64'(sat_sum), 64'd36);
    tick();

    // 4: start and coefficient write during RUN are ignored
    start_run(16'd1);
    start = 1'b1; v_we = 1'b1; v_addr = 3'd0; v_wdata = 16'd100;
    tick();
    start = 1'b0; v_we = 1'b0;
    wait_result(1);
    acks = 0;
    repeat (10) begin
      tick();
      if (ack === 1'b1) acks++;
    end
    chk("t4_single_ack", 64'(acks), 64'd0);
    start_run(16'd1);
    wait_result(0);
    chk("t4_v0_kept", 64'(sum), 64'd36);
    tick();

    // 5: reset in the third RUN cycle discards the result
    start_run(16'd1);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) mv[i] = 16'd1;
    void'(q_sum.pop_back()); void'(q_ovf.pop_back());
    void'(q_ssum.pop_back()); void'(q_sovf.pop_back());
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_ack", 64'(ack), 64'd0);
    chk("t5_sum", 64'(sum), 64'd0);
    chk("t5_ovf", 64'(ovf), 64'd0);
    acks = 0;
    repeat (12) begin
      tick();
      if (ack === 1'b1) acks++;
    end
    chk("t5_no_ack", 64'(acks), 64'd0);
    start_run(16'd1);
    wait_result(0);
    chk("t5_sum36", 64'(sum), 64'd36);
    tick();

    // 6: start held high; write in DONE applies to the following run
    n = 16'd1;
    start = 1'b1;
    push_exp(16'd1);
    tick();
    for (int r = 0; r < 3; r++) begin
      wait_result(0);
      if (r > 0) chk("t6_period", 64'(ack_cyc - prev_ack), 64'd9);
      prev_ack = ack_cyc;
      if (r < 2) begin
        if (r == 1) begin
          v_we = 1'b1; v_addr = 3'd3; v_wdata = 16'd5; mv[3] = 16'd5;
        end
        push_exp(16'd1);
        tick();
        v_we = 1'b0;
      end
    end
    chk("t6_sum52", 64'(sum), 64'd52);
    start = 1'b0;
    tick(); tick();
    chk("t6_idle", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
